// File: rtl/pwm_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi_ctrl
//  Purpose  : Multi-channel PWM controller. One shared period counter drives
//             CHANNELS PWM outputs. Each channel's duty is edited in STEP
//             increments by asynchronous inc/dec buttons. The selected
//             channel's pending duty is shown in decimal on three active-low
//             seven-segment digits.
//  Ports    : clk, rst (async, active-high)
//             en            - global enable (asynchronous level)
//             inc, dec      - duty buttons (asynchronous, sub-cycle pulses ok)
//             sel[SW-1:0]   - channel selected for edit and display
//             pwm_out[CH-1:0] - registered PWM outputs
//             HEX0/1/2[6:0] - ones/tens/hundreds, active-low {g,f,e,d,c,b,a}
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ctrl #(
  parameter int CHANNELS  = 4,
  parameter int PERIOD    = 100,
  parameter int STEP      = 10,
  parameter int DUTY_INIT = 0,
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                inc,
  input  logic                dec,
  input  logic [SW-1:0]       sel,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2
);

  localparam int CW = $clog2(PERIOD);
  localparam int DW = $clog2(PERIOD + 1);

  localparam logic [CW-1:0] C_CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [DW:0]   C_PERIOD_X  = (DW + 1)'(PERIOD);
  localparam logic [DW:0]   C_STEP_X    = (DW + 1)'(STEP);
  localparam logic [DW-1:0] C_PERIOD_D  = DW'(PERIOD);
  localparam logic [DW-1:0] C_STEP_D    = DW'(STEP);
  localparam logic [DW-1:0] C_DUTY_INIT = DW'(DUTY_INIT);
  localparam logic [6:0]    C_BLANK     = 7'b1111111;

  // --------------------------------------------------------------------------
  // Button capture: a sticky flop set by the button edge itself, so pulses
  // narrower than a clock period are never lost. It is cleared once the first
  // synchroniser stage has taken the 1, which keeps the clear synchronous to
  // clk while the set stays fully asynchronous.
  // --------------------------------------------------------------------------
  logic inc_lat_q, dec_lat_q;
  logic inc_s1_q, inc_s2_q, inc_s3_q, inc_ev_q;
  logic dec_s1_q, dec_s2_q, dec_s3_q, dec_ev_q;
  logic en_s1_q, en_sync_q;
  logic w_inc_clr, w_dec_clr;

  assign w_inc_clr = rst | inc_s1_q;
  assign w_dec_clr = rst | dec_s1_q;

  always_ff @(posedge inc or posedge w_inc_clr) begin
    if (w_inc_clr) inc_lat_q <= 1'b0;
    else           inc_lat_q <= 1'b1;
  end

  always_ff @(posedge dec or posedge w_dec_clr) begin
    if (w_dec_clr) dec_lat_q <= 1'b0;
    else           dec_lat_q <= 1'b1;
  end

  // Two-flop synchronisers, then a registered rising-edge detect so each
  // press becomes exactly one single-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_s1_q  <= 1'b0;
      inc_s2_q  <= 1'b0;
      inc_s3_q  <= 1'b0;
      inc_ev_q  <= 1'b0;
      dec_s1_q  <= 1'b0;
      dec_s2_q  <= 1'b0;
      dec_s3_q  <= 1'b0;
      dec_ev_q  <= 1'b0;
      en_s1_q   <= 1'b0;
      en_sync_q <= 1'b0;
    end else begin
      inc_s1_q  <= inc_lat_q;
      inc_s2_q  <= inc_s1_q;
      inc_s3_q  <= inc_s2_q;
      inc_ev_q  <= inc_s2_q & ~inc_s3_q;
      dec_s1_q  <= dec_lat_q;
      dec_s2_q  <= dec_s1_q;
      dec_s3_q  <= dec_s2_q;
      dec_ev_q  <= dec_s2_q & ~dec_s3_q;
      en_s1_q   <= en;
      en_sync_q <= en_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Shared period counter
  // --------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] w_cnt_ext;
  logic          w_wrap;
  logic          w_load;

  assign w_wrap    = en_sync_q && (cnt_q == C_CNT_LAST);
  // While disabled the active duty tracks the pending duty every cycle, so a
  // freshly enabled channel starts directly with its edited value.
  assign w_load    = w_wrap || !en_sync_q;
  assign w_cnt_ext = DW'(cnt_q);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en_sync_q || w_wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // --------------------------------------------------------------------------
  // Channel selection. sel is widened by one bit so an out-of-range channel
  // number is a genuine comparison for any CHANNELS value.
  // --------------------------------------------------------------------------
  logic [SW:0] w_sel_ext;
  logic        w_sel_valid;
  logic        w_edit;

  assign w_sel_ext   = {1'b0, sel};
  assign w_sel_valid = (w_sel_ext < (SW + 1)'(CHANNELS));
  // Simultaneous inc and dec cancel out.
  assign w_edit      = w_sel_valid && (inc_ev_q ^ dec_ev_q);

  logic [DW-1:0]       w_pend [CHANNELS];
  logic [CHANNELS-1:0] w_pwm;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DW-1:0] pend_q, pend_d, act_q;
    logic [DW:0]   w_sum;
    logic          w_hit;
    logic          pwm_q;

    assign w_hit = w_edit && (w_sel_ext == (SW + 1)'(i));
    // One bit wider than the duty so the saturation test is exact.
    assign w_sum = {1'b0, pend_q} + C_STEP_X;

    always_comb begin
      pend_d = pend_q;
      if (w_hit) begin
        if (inc_ev_q) begin
          pend_d = (w_sum > C_PERIOD_X) ? C_PERIOD_D : w_sum[DW-1:0];
        end else begin
          pend_d = ({1'b0, pend_q} < C_STEP_X) ? '0 : (pend_q - C_STEP_D);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= C_DUTY_INIT;
        act_q  <= C_DUTY_INIT;
        pwm_q  <= 1'b0;
      end else begin
        pend_q <= pend_d;
        if (w_load) act_q <= pend_q;
        pwm_q  <= en_sync_q && (w_cnt_ext < act_q);
      end
    end

    assign w_pend[i] = pend_q;
    assign w_pwm[i]  = pwm_q;
  end

  assign pwm_out = w_pwm;

  // --------------------------------------------------------------------------
  // Display: mux the selected pending duty, convert to BCD with a
  // combinational shift-and-add-3, then register the segment patterns.
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_disp;
  logic [9:0]    w_bin;
  logic [11:0]   w_bcd;
  logic [3:0]    w_hund, w_tens, w_ones;

  always_comb begin
    w_disp = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_sel_ext == (SW + 1)'(c)) w_disp = w_pend[c];
    end
  end

  assign w_bin = 10'(w_disp);

  always_comb begin
    w_bcd = '0;
    for (int b = 9; b >= 0; b--) begin
      for (int n = 0; n < 3; n++) begin
        if (w_bcd[n*4 +: 4] > 4'd4) w_bcd[n*4 +: 4] = w_bcd[n*4 +: 4] + 4'd3;
      end
      w_bcd = {w_bcd[10:0], w_bin[b]};
    end
  end

  assign w_hund = w_bcd[11:8];
  assign w_tens = w_bcd[7:4];
  assign w_ones = w_bcd[3:0];

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = C_BLANK;
    endcase
  endfunction

  logic [6:0] hex0_q, hex1_q, hex2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex0_q <= C_BLANK;
      hex1_q <= C_BLANK;
      hex2_q <= C_BLANK;
    end else begin
      // Leading-zero blanking; the ones digit is always lit for a valid sel.
      hex0_q <= w_sel_valid ? f_seg(w_ones) : C_BLANK;
      hex1_q <= (w_sel_valid && ((w_hund != 4'd0) || (w_tens != 4'd0))) ? f_seg(w_tens) : C_BLANK;
      hex2_q <= (w_sel_valid && (w_hund != 4'd0)) ? f_seg(w_hund) : C_BLANK;
    end
  end

  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_multi_ctrl
//  Purpose  : Self-checking bench for pwm_multi_ctrl. A behavioural model
//             predicts pwm_out and HEX0..2 every cycle from the duty rules;
//             a few hand-computed literals pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ctrl;

  localparam int CH = 4;
  localparam int P  = 100;
  localparam int ST = 10;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;

  logic          clk = 1'b0;
  logic          rst, en, inc, dec;
  logic [1:0]    sel;
  logic [CH-1:0] pwm;
  logic [6:0]    h0, h1, h2;

  // Second instance with three channels, always pointed at channel 3.
  logic [1:0] sel3;
  logic [2:0] pwm3;
  logic [6:0] h30, h31, h32;

  always #5 clk = ~clk;

  pwm_multi_ctrl #(.CHANNELS(CH), .PERIOD(P), .STEP(ST), .DUTY_INIT(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .sel(sel),
    .pwm_out(pwm), .HEX0(h0), .HEX1(h1), .HEX2(h2));

  pwm_multi_ctrl #(.CHANNELS(3), .PERIOD(P), .STEP(ST), .DUTY_INIT(0)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .sel(sel3),
    .pwm_out(pwm3), .HEX0(h30), .HEX1(h31), .HEX2(h32));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  int         m_pend [CH];
  int         m_act  [CH];
  int         m_pwm  [CH];
  logic [6:0] m_h0, m_h1, m_h2;
  int         m_ih [3];
  int         m_dh [3];
  int         m_en_h [2];
  int         m_inc_flag, m_dec_flag;
  int         m_prev_ens;
  int         m_n, m_n0;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
      m_pwm[i]  = 0;
    end
    for (int j = 0; j < 3; j++) begin
      m_ih[j] = 0;
      m_dh[j] = 0;
    end
    m_en_h[0] = 0;
    m_en_h[1] = 0;
    m_h0 = BLANK; m_h1 = BLANK; m_h2 = BLANK;
    m_inc_flag = 0; m_dec_flag = 0;
    m_prev_ens = 0; m_n = 0; m_n0 = 0;
  endtask

  // Called once per rising edge with the inputs the DUT sees at that edge.
  task automatic model_step();
    int ens, ph, v;
    if (rst) begin
      model_reset();
      return;
    end
    ens = m_en_h[1];                     // en as sampled two edges ago
    if ((ens != 0) && (m_prev_ens == 0)) m_n0 = m_n;
    ph = (ens != 0) ? (m_n - m_n0) % P : 0;   // position within the period
    for (int i = 0; i < CH; i++) m_pwm[i] = ((ens != 0) && (ph < m_act[i])) ? 1 : 0;
    v = m_pend[sel];
    m_h2 = (v >= 100) ? seg(v / 100) : BLANK;
    m_h1 = (v >= 10) ? seg((v / 10) % 10) : BLANK;
    m_h0 = seg(v % 10);
    // New duty takes effect at a period start, or continuously while disabled.
    if ((ens == 0) || (ph == P - 1)) begin
      for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
    end
    // A press seen at edge k edits the pending duty at edge k+3.
    if ((m_ih[2] != 0) && (m_dh[2] == 0)) begin
      m_pend[sel] = (m_pend[sel] + ST > P) ? P : m_pend[sel] + ST;
    end else if ((m_dh[2] != 0) && (m_ih[2] == 0)) begin
      m_pend[sel] = (m_pend[sel] < ST) ? 0 : m_pend[sel] - ST;
    end
    m_ih[2] = m_ih[1]; m_ih[1] = m_ih[0]; m_ih[0] = m_inc_flag;
    m_dh[2] = m_dh[1]; m_dh[1] = m_dh[0]; m_dh[0] = m_dec_flag;
    m_inc_flag = 0; m_dec_flag = 0;
    m_en_h[1] = m_en_h[0];
    m_en_h[0] = en ? 1 : 0;
    m_prev_ens = ens;
    m_n++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < CH; i++) chk($sformatf("pwm_out[%0d]", i), int'(pwm[i]), m_pwm[i]);
    chk("HEX0", int'(h0), int'(m_h0));
    chk("HEX1", int'(h1), int'(m_h1));
    chk("HEX2", int'(h2), int'(m_h2));
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // 1 ns pulse placed mid-cycle, then enough idle cycles for the press to land.
  task automatic press(input bit pi, input bit pd);
    cyc();
    #2;
    inc = pi;
    dec = pd;
    if (pi) m_inc_flag = 1;
    if (pd) m_dec_flag = 1;
    #1;
    inc = 1'b0;
    dec = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic count_high(input int ch, output int c);
    c = 0;
    repeat (P) begin
      cyc();
      c += int'(pwm[ch]);
    end
  endtask

  task automatic count_others(input int ch, output int hi_ch, output int hi_oth);
    hi_ch = 0;
    hi_oth = 0;
    repeat (P) begin
      cyc();
      for (int i = 0; i < CH; i++) begin
        if (i == ch) hi_ch += int'(pwm[i]);
        else         hi_oth += int'(pwm[i]);
      end
    end
  endtask

  task automatic set_sel(input int s);
    cyc();
    #1 sel = 2'(s);
  endtask

  initial begin
    int c, co;
    rst = 1'b0; en = 1'b0; inc = 1'b0; dec = 1'b0; sel = 2'd0; sel3 = 2'd3;
    model_reset();
    #1 rst = 1'b1;
    model_reset();
    repeat (3) cyc();
    chk("reset HEX0 literal", int'(h0), int'(BLANK));
    chk("reset pwm literal", int'(pwm), 0);
    #1 rst = 1'b0;

    // 1: single inc on channel 0
    cyc();
    #1 en = 1'b1;
    repeat (5) cyc();
    press(1'b1, 1'b0);
    repeat (P + 5) cyc();
    chk("t1 model pend0", m_pend[0], 10);
    chk("t1 HEX2", int'(h2), int'(BLANK));
    chk("t1 HEX1", int'(h1), int'(S1));
    chk("t1 HEX0", int'(h0), int'(S0));
    count_others(0, c, co);
    chk("t1 high count ch0", c, 10);
    chk("t1 high count others", co, 0);

    // 2: +2 -1 -> 20
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    repeat (P + 5) cyc();
    count_high(0, c);
    chk("t2 high count ch0", c, 20);

    // 3: saturation on channel 2
    set_sel(2);
    repeat (12) press(1'b1, 1'b0);
    repeat (P + 5) cyc();
    chk("t3 HEX2 hundred", int'(h2), int'(S1));
    chk("t3 HEX1 hundred", int'(h1), int'(S0));
    chk("t3 HEX0 hundred", int'(h0), int'(S0));
    count_high(2, c);
    chk("t3 high count full", c, P);
    repeat (12) press(1'b0, 1'b1);
    repeat (P + 5) cyc();
    chk("t3 HEX2 zero", int'(h2), int'(BLANK));
    chk("t3 HEX1 zero", int'(h1), int'(BLANK));
    chk("t3 HEX0 zero", int'(h0), int'(S0));
    count_high(2, c);
    chk("t3 high count empty", c, 0);

    // 4: simultaneous inc+dec, and out-of-range sel on the 3-channel instance
    set_sel(1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    repeat (3) cyc();
    chk("t4 model pend1", m_pend[1], 10);
    chk("t4 HEX1", int'(h1), int'(S1));
    chk("t4 HEX0", int'(h0), int'(S0));
    chk("t4 dut3 HEX0 blank", int'(h30), int'(BLANK));
    chk("t4 dut3 HEX1 blank", int'(h31), int'(BLANK));
    chk("t4 dut3 HEX2 blank", int'(h32), int'(BLANK));
    chk("t4 dut3 pwm", int'(pwm3), 0);

    // 5: disable mid-period at 50, edit to 70, re-enable
    set_sel(0);
    repeat (3) press(1'b1, 1'b0);
    repeat (P + 37) cyc();
    #1 en = 1'b0;
    repeat (3) cyc();
    chk("t5 pwm off after disable", int'(pwm), 0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    repeat (5) cyc();
    #1 en = 1'b1;
    repeat (2) cyc();
    count_high(0, c);
    chk("t5 first period ch0", c, 70);

    // 6: asynchronous reset mid-period
    repeat (20) cyc();
    chk("t6 pwm0 high before reset", int'(pwm[0]), 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6 pwm immediate", int'(pwm), 0);
    chk("t6 HEX0 immediate", int'(h0), int'(BLANK));
    chk("t6 HEX1 immediate", int'(h1), int'(BLANK));
    chk("t6 HEX2 immediate", int'(h2), int'(BLANK));
    repeat (2) cyc();
    #1 rst = 1'b0;
    repeat (3) cyc();
    for (int s = 0; s < CH; s++) begin
      set_sel(s);
      repeat (2) cyc();
      chk($sformatf("t6 HEX0 ch%0d zero", s), int'(h0), int'(S0));
      chk($sformatf("t6 HEX1 ch%0d blank", s), int'(h1), int'(BLANK));
    end

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        int k;
        set_sel(int'($urandom_range(0, CH - 1)));
        k = int'($urandom_range(0, 2));
        press(k != 1, k != 0);
      end else if (r == 5) begin
        cyc();
        #1 en = ~en;
      end else if (r == 6) begin
        set_sel(int'($urandom_range(0, CH - 1)));
      end else begin
        repeat (int'($urandom_range(1, 20))) cyc();
      end
    end
    repeat (P + 5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_multi_ctrl.md
# pwm_multi_ctrl

Parametrised multi-channel PWM controller driving `CHANNELS` independent PWM outputs from one shared period counter. Each channel has its own duty setting, raised or lowered in `STEP` increments by edge-detected, synchronised button inputs. The selected channel's duty is shown in decimal on three active-low seven-segment displays. It replaces the single-channel fixed-step PWM top and sits between the board switches and the LED/motor pins.

## Interface
- `CHANNELS`, default 4: number of PWM outputs (1..16).
- `PERIOD`, default 100: PWM period in clocks; duty range is 0..`PERIOD` (2..999).
- `STEP`, default 10: duty change per inc/dec event (1..`PERIOD`).
- `DUTY_INIT`, default 0: reset duty of every channel (0..`PERIOD`).
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: asynchronous reset, active-high.
- `en` in 1: global enable, level, asynchronous to `clk`.
- `inc` in 1: duty-up button, asynchronous. Pulses may be shorter than a clock period and must be caught; see Operation.
- `dec` in 1: duty-down button, asynchronous, same rules as `inc`.
- `sel` in SW=max(1,$clog2(CHANNELS)): channel selected for edit and display.
- `pwm_out` out CHANNELS: PWM outputs, registered.
- `HEX0` out 7: ones digit, active-low, bit order {g,f,e,d,c,b,a}.
- `HEX1` out 7: tens digit, same encoding.
- `HEX2` out 7: hundreds digit, same encoding.

## Operation
- Input capture:
  - `inc` and `dec` each set a sticky latch. The latch is cleared synchronously after its value has been sampled by the synchroniser.
  - This guarantees capture of sub-cycle pulses.
  - `en`, the `inc` latch and the `dec` latch each pass through a 2-flop synchroniser.
  - Rising-edge detect on the synchronised `inc` and `dec` gives 1-cycle events `inc_ev` and `dec_ev`.
- Period counter `cnt`, width $clog2(PERIOD):
  - Counts 0..`PERIOD`-1, then wraps to 0 while synchronised `en`=1.
  - Held at 0 while `en`=0.
- Per channel, two registers of width $clog2(PERIOD+1):
  - `duty_pend[i]`: the edited value.
  - `duty_act[i]`: the value in use for output.
- Edit rules, applied to `duty_pend[sel]` only:
  - `inc_ev` alone: min(d+`STEP`, `PERIOD`).
  - `dec_ev` alone: d-`STEP`, or 0 if d<`STEP`. Saturates, never wraps.
  - `inc_ev` and `dec_ev` in the same cycle: no change.
  - `sel` ≥ `CHANNELS`: events are ignored.
  - Edits are accepted regardless of `en`.
  - Compute the sum one bit wider so saturation is exact.
- Glitch-free update:
  - `duty_act[i]` <= `duty_pend[i]` on the cycle `cnt` wraps from `PERIOD`-1 to 0.
  - It also updates on every cycle while `en`=0, so a channel starts with its pending value.
- Output: `pwm_out[i]` <= `en_sync` && (`cnt` < `duty_act[i]`).
  - Duty 0 gives a constant 0.
  - Duty `PERIOD` gives a constant 1 while enabled.
- Display:
  - Shows `duty_pend[sel]` as three decimal digits. HEX2 is hundreds, HEX1 tens, HEX0 ones.
  - Leading zeros are blanked (7'b1111111). Ones is always shown.
  - Digits 0–9 use the standard active-low patterns, e.g. "0"=7'b1000000, "1"=7'b1111001.
  - `sel` ≥ `CHANNELS`: all three digits blank.
  - Binary-to-BCD conversion is combinational. HEX outputs are registered.
- Reset (`rst`=1, asynchronous), values take effect immediately:
  - Latches, synchronisers and edge detectors: 0.
  - `cnt`: 0.
  - All `duty_pend` and `duty_act`: `DUTY_INIT`.
  - `pwm_out`: 0.
  - HEX0/1/2: 7'b1111111.
  - Reset mid-period aborts the period. No partial pulse is produced after reset release until `en_sync` returns.

## Timing
- `inc`/`dec` latency:
  - Latch sampled at edge k, synchronised at k+1, event at k+2.
  - `duty_pend` updated at edge k+3.
  - HEX updated at k+4.
- `en` latency:
  - `en` rise sampled at edge k; `en_sync`=1 after k+1.
  - `cnt` starts counting and `pwm_out` may assert after edge k+2.
  - `en` fall forces `pwm_out`=0 two edges after the sampling edge.
- `sel` change: HEX reflects the new channel one edge later.
- New `duty_pend` appears on `pwm_out` from the first period starting after the update. Worst case this is `PERIOD`+1 cycles after the update.
- Repeated presses: events closer than 2 cycles apart may merge into one. Presses are human-rate, so this is acceptable.

## Test plan
Parameters are defaults throughout (CHANNELS=4, PERIOD=100, STEP=10, DUTY_INIT=0).
1. Reset, then `en`=1, `sel`=0, one 1 ns `inc` pulse -> `duty_pend[0]`=10; HEX2/HEX1/HEX0 = blank/"1"/"0"; next period `pwm_out[0]` high exactly 10 of 100 clocks; other outputs stay 0.
2. Starting from test 1 state: two further `inc` pulses then one `dec` on `sel`=0 -> duty 20; `pwm_out[0]` high 20/100 clocks; the high time changes only at a period boundary, never mid-period.
3. Saturation: 12 `inc` on `sel`=2 -> duty 100, HEX shows "100", `pwm_out[2]` constant 1; then 12 `dec` -> duty 0, HEX shows blank/blank/"0", `pwm_out[2]` constant 0.
4. `inc` and `dec` asserted together -> no duty change. With CHANNELS=3, `sel`=3 plus `inc` -> no duty change and all HEX digits blank.
5. `en`=0 mid-period with duty 50 -> `pwm_out` all 0 within 3 edges and `cnt` at 0. Edit to 70 while disabled; re-enable -> the first period is already 70/100.
6. Assert `rst` mid-period -> `pwm_out`=0 and HEX all ones immediately, before the next clock edge; after release all duties read 0.
